// File: rtl/hiscore_xfer_pkg.sv
// rtl/hiscore_xfer_pkg.sv - state encoding and default window/settle constants for the hiscore controller
package hiscore_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_TX,
    ST_WR_RECV,
    ST_WR_STB,
    ST_REL
  } state_t;

  localparam logic [15:0] DEF_BASE   = 16'h0000;
  localparam logic [15:0] DEF_LEN    = 16'd64;
  localparam int          DEF_SETTLE = 4;

  // settle counter width; SETTLE must fit in it and be at least 1
  localparam int          CNT_W      = 8;

endpackage

// File: rtl/hiscore_xfer_if.sv
// rtl/hiscore_xfer_if.sv - RAM hiscore port plus save/load byte links
interface hiscore_xfer_if;

  logic        hs_access;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;

  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;

  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;

  modport master (
    output hs_access, hs_address, hs_data_in, hs_write,
    input  hs_data_out,
    output TX_DATA, TX_VALID,
    input  TX_READY,
    input  RX_DATA, RX_VALID,
    output RX_READY
  );

  modport slave (
    input  hs_access, hs_address, hs_data_in, hs_write,
    output hs_data_out,
    input  TX_DATA, TX_VALID,
    output TX_READY,
    output RX_DATA, RX_VALID,
    input  RX_READY
  );

endinterface

// File: rtl/hiscore_xfer_settle_cnt.sv
// rtl/hiscore_xfer_settle_cnt.sv - loadable down-counter timing the RAM clock-mux settle gaps
module hs_settle_cnt
  import hiscore_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // load wins over decrement; decrement parks at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hiscore_xfer.sv
// rtl/hiscore_xfer.sv - hiscore save/load controller owning the video RAM hiscore port
module hiscore_xfer
  import hiscore_pkg::*;
#(
  parameter logic [15:0] BASE   = DEF_BASE,
  parameter logic [15:0] LEN    = DEF_LEN,
  parameter int          SETTLE = DEF_SETTLE
) (
  input  logic           DLCL,
  input  logic           RSTn,
  input  logic           SAVE_REQ,
  input  logic           LOAD_REQ,
  hiscore_xfer_if.master bus,
  output logic           BUSY,
  output logic           DONE
);

  // counter counts SETTLE-1 down to zero, giving SETTLE cycles in ACQ and in REL
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

  state_t      r_state;
  logic        r_mode_save;
  logic        r_access;
  logic        r_write;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_idx;
  logic [15:0] r_address;
  logic [7:0]  r_data_in;
  logic [7:0]  r_tx_data;

  logic [15:0] w_idx_nxt;
  logic        w_settle;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        w_cnt_zero;

  assign w_idx_nxt = r_idx + 16'd1;
  assign w_settle  = (r_state == ST_ACQ) || (r_state == ST_REL);
  // reload whenever not settling, and again as ACQ ends so an empty window enters REL with a full count
  assign w_cnt_load = !w_settle || ((r_state == ST_ACQ) && w_cnt_zero);
  assign w_cnt_dec  = w_settle;

  hs_settle_cnt u_settle (
    .i_clk      (DLCL),
    .i_rst_n    (RSTn),
    .i_load     (w_cnt_load),
    .i_load_val (SETTLE_LD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // transfer sequencer; every RAM-side and link output is registered here
  always_ff @(posedge DLCL or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_mode_save <= 1'b0;
      r_access    <= 1'b0;
      r_write     <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_idx       <= '0;
      r_address   <= '0;
      r_data_in   <= '0;
      r_tx_data   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (SAVE_REQ || LOAD_REQ) begin
            r_mode_save <= SAVE_REQ;
            r_idx       <= '0;
            r_access    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (w_cnt_zero) begin
            if (r_idx == LEN) begin
              r_state <= ST_REL;
            end else if (r_mode_save) begin
              r_address <= BASE + r_idx;
              r_state   <= ST_RD_ADDR;
            end else begin
              r_state <= ST_WR_RECV;
            end
          end
        end
        ST_RD_ADDR: begin
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          r_tx_data  <= bus.hs_data_out;
          r_tx_valid <= 1'b1;
          r_state    <= ST_TX;
        end
        ST_TX: begin
          if (bus.TX_READY) begin
            r_tx_valid <= 1'b0;
            r_idx      <= w_idx_nxt;
            if (w_idx_nxt == LEN) begin
              r_state <= ST_REL;
            end else begin
              r_address <= BASE + w_idx_nxt;
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_RECV: begin
          if (bus.RX_VALID) begin
            r_data_in <= bus.RX_DATA;
            r_address <= BASE + r_idx;
            r_write   <= 1'b1;
            r_state   <= ST_WR_STB;
          end
        end
        ST_WR_STB: begin
          r_write <= 1'b0;
          r_idx   <= w_idx_nxt;
          r_state <= (w_idx_nxt == LEN) ? ST_REL : ST_WR_RECV;
        end
        ST_REL: begin
          if (w_cnt_zero) begin
            r_access <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.hs_access  = r_access;
  assign bus.hs_address = r_address;
  assign bus.hs_data_in = r_data_in;
  assign bus.hs_write   = r_write;
  assign bus.TX_DATA    = r_tx_data;
  assign bus.TX_VALID   = r_tx_valid;
  assign bus.RX_READY   = (r_state == ST_WR_RECV);
  assign BUSY           = r_busy;
  assign DONE           = r_done;

endmodule

// File: tb/tb_hiscore_xfer.sv
// tb/tb_hiscore_xfer.sv - self-checking bench for hiscore_xfer
module tb_hiscore_xfer;

  localparam int          S      = 4;
  localparam logic [15:0] M_BASE = 16'h0F00;
  localparam logic [15:0] M_LEN  = 16'd4;
  localparam logic [15:0] W_BASE = 16'hFFFE;

  logic clk = 1'b0;
  logic rst_n;
  logic m_save, m_load, m_busy, m_done;
  logic w_save, w_busy, w_done;
  logic z_save, z_busy, z_done;

  hiscore_xfer_if bus_m ();
  hiscore_xfer_if bus_w ();
  hiscore_xfer_if bus_z ();

  always #5 clk = ~clk;

  hiscore_xfer #(.BASE(M_BASE), .LEN(M_LEN), .SETTLE(S)) u_main (
    .DLCL(clk), .RSTn(rst_n), .SAVE_REQ(m_save), .LOAD_REQ(m_load),
    .bus(bus_m.master), .BUSY(m_busy), .DONE(m_done));

  hiscore_xfer #(.BASE(W_BASE), .LEN(16'd4), .SETTLE(S)) u_wrap (
    .DLCL(clk), .RSTn(rst_n), .SAVE_REQ(w_save), .LOAD_REQ(1'b0),
    .bus(bus_w.master), .BUSY(w_busy), .DONE(w_done));

  hiscore_xfer #(.BASE(16'h0100), .LEN(16'd0), .SETTLE(S)) u_zero (
    .DLCL(clk), .RSTn(rst_n), .SAVE_REQ(z_save), .LOAD_REQ(1'b0),
    .bus(bus_z.master), .BUSY(z_busy), .DONE(z_done));

  // main RAM: synchronous, one-cycle read latency, plus a preload port
  logic [7:0]  ram [65536];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus_m.hs_access && bus_m.hs_write) ram[bus_m.hs_address] <= bus_m.hs_data_in;
    bus_m.hs_data_out <= ram[bus_m.hs_address];
  end

  // wrap RAM returns a pattern derived from the address it saw
  always @(posedge clk) bus_w.hs_data_out <= bus_w.hs_address[7:0] ^ 8'h3C;
  assign bus_w.TX_READY = 1'b1;
  assign bus_w.RX_VALID = 1'b0;
  assign bus_w.RX_DATA  = 8'h00;
  assign bus_z.TX_READY = 1'b1;
  assign bus_z.RX_VALID = 1'b1;
  assign bus_z.RX_DATA  = 8'h00;
  assign bus_z.hs_data_out = 8'h00;

  int checks, errors;
  logic [7:0]  model [65536];
  logic [7:0]  tx_q[$];
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  logic [7:0]  rx_bytes[$];
  int          rx_gaps[$];
  int          rx_pos, gap_left;
  int          n, acc_cyc, busy_cyc, done_cnt, first_vld;
  int          stall_byte, stall_left;
  bit          rnd, pulse_load, prev_hold;
  logic [7:0]  prev_data;
  logic [15:0] w_addr_q[$];
  logic [7:0]  w_data_q[$];
  int          w_acc, w_done_cnt, z_acc, z_viol, z_done_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    tx_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    w_addr_q.delete(); w_data_q.delete();
    n = 0; acc_cyc = 0; busy_cyc = 0; done_cnt = 0; first_vld = -1;
    stall_byte = -1; stall_left = 0; rnd = 0; pulse_load = 0; prev_hold = 0;
    w_acc = 0; w_done_cnt = 0; z_acc = 0; z_viol = 0; z_done_cnt = 0;
    rx_pos = 0;
    gap_left = (rx_gaps.size() > 0) ? rx_gaps[0] : 0;
  endtask

  // one clock: observe on the falling edge, then set inputs for the next rising edge
  task automatic tick();
    @(negedge clk);
    if (prev_hold) begin
      check("tx_hold_valid", bus_m.TX_VALID, 1);
      check("tx_hold_data", bus_m.TX_DATA, prev_data);
    end
    if (bus_m.hs_access) acc_cyc++;
    if (m_busy) busy_cyc++;
    if (m_done) done_cnt++;
    if (bus_m.TX_VALID && first_vld < 0) first_vld = n;
    if (bus_m.hs_write) begin
      wr_a_q.push_back(bus_m.hs_address);
      wr_d_q.push_back(bus_m.hs_data_in);
    end
    if (bus_w.hs_access) w_acc++;
    if (w_done) w_done_cnt++;
    if (bus_w.TX_VALID) begin
      w_addr_q.push_back(bus_w.hs_address);
      w_data_q.push_back(bus_w.TX_DATA);
    end
    if (bus_z.hs_access) z_acc++;
    if (bus_z.TX_VALID || bus_z.hs_write || bus_z.RX_READY) z_viol++;
    if (z_done) z_done_cnt++;

    if (n == 0) begin m_save = 0; m_load = 0; end
    if (pulse_load) m_load = (n >= 8 && n < 10);

    if (rnd) bus_m.TX_READY = ($urandom_range(0, 2) != 0);
    else if (bus_m.TX_VALID && tx_q.size() == stall_byte && stall_left > 0) begin
      bus_m.TX_READY = 1'b0;
      stall_left--;
    end else bus_m.TX_READY = 1'b1;
    if (bus_m.TX_VALID && bus_m.TX_READY) tx_q.push_back(bus_m.TX_DATA);
    prev_hold = bus_m.TX_VALID && !bus_m.TX_READY;
    prev_data = bus_m.TX_DATA;

    bus_m.RX_VALID = 1'b0;
    if (bus_m.RX_READY && rx_pos < rx_bytes.size()) begin
      if (rnd) bus_m.RX_VALID = 1'($urandom_range(0, 1));
      else if (gap_left > 0) gap_left--;
      else bus_m.RX_VALID = 1'b1;
      bus_m.RX_DATA = rx_bytes[rx_pos];
      if (bus_m.RX_VALID) begin
        rx_pos++;
        gap_left = (rx_pos < rx_gaps.size()) ? rx_gaps[rx_pos] : 0;
      end
    end
    n++;
  endtask

  task automatic run_main(input logic s, input logic l, input bit pulse, input int stall,
                          input bit rand_mode, input int budget, output bit finished);
    clear_stats();
    pulse_load = pulse;
    stall_byte = (stall > 0) ? 2 : -1;
    stall_left = stall;
    rnd = rand_mode;
    m_save = s; m_load = l;
    finished = 0;
    for (int i = 0; i < budget && !finished; i++) begin
      tick();
      finished = (done_cnt > 0);
    end
    repeat (3) tick();
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    model[a] = d;
  endtask

  task automatic check_save(input string tag);
    logic [15:0] a;
    check({tag, "_tx_count"}, tx_q.size(), int'(M_LEN));
    for (int k = 0; k < tx_q.size() && k < int'(M_LEN); k++) begin
      a = M_BASE + 16'(k);
      check({tag, "_tx_data"}, tx_q[k], model[a]);
    end
    check({tag, "_no_write"}, wr_a_q.size(), 0);
  endtask

  task automatic check_load(input string tag);
    logic [15:0] a;
    check({tag, "_wr_count"}, wr_a_q.size(), int'(M_LEN));
    for (int k = 0; k < wr_a_q.size() && k < int'(M_LEN); k++) begin
      a = M_BASE + 16'(k);
      check({tag, "_wr_addr"}, wr_a_q[k], a);
      check({tag, "_wr_data"}, wr_d_q[k], rx_bytes[k]);
    end
    for (int k = 0; k < int'(M_LEN); k++) begin
      a = M_BASE + 16'(k);
      model[a] = rx_bytes[k];
      check({tag, "_readback"}, ram[a], model[a]);
    end
    check({tag, "_no_tx"}, tx_q.size(), 0);
  endtask

  typedef struct {
    logic save;
    logic load;
    bit   pulse;
    int   stall;
    bit   exp_start;
    bit   exp_save;
  } vec_t;

  vec_t        vecs[5];
  bit          fin;
  int          exp_acc;
  logic [15:0] ea;
  logic [7:0]  ed;
  bit          mode_save;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 0; m_save = 0; m_load = 0; w_save = 0; z_save = 0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    bus_m.TX_READY = 0; bus_m.RX_VALID = 0; bus_m.RX_DATA = '0;
    repeat (3) @(negedge clk);
    check("rst_access", bus_m.hs_access, 0);
    check("rst_write", bus_m.hs_write, 0);
    check("rst_address", bus_m.hs_address, 0);
    check("rst_data_in", bus_m.hs_data_in, 0);
    check("rst_tx_valid", bus_m.TX_VALID, 0);
    check("rst_tx_data", bus_m.TX_DATA, 0);
    check("rst_rx_ready", bus_m.RX_READY, 0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) preload(M_BASE + 16'(k), 8'hA0 + 8'(k));

    vecs[0] = '{save: 1'b1, load: 1'b0, pulse: 1'b0, stall: 0,  exp_start: 1'b1, exp_save: 1'b1};
    vecs[1] = '{save: 1'b0, load: 1'b1, pulse: 1'b0, stall: 0,  exp_start: 1'b1, exp_save: 1'b0};
    vecs[2] = '{save: 1'b1, load: 1'b1, pulse: 1'b1, stall: 0,  exp_start: 1'b1, exp_save: 1'b1};
    vecs[3] = '{save: 1'b0, load: 1'b0, pulse: 1'b0, stall: 0,  exp_start: 1'b0, exp_save: 1'b0};
    vecs[4] = '{save: 1'b1, load: 1'b0, pulse: 1'b0, stall: 10, exp_start: 1'b1, exp_save: 1'b1};

    for (int v = 0; v < 5; v++) begin
      rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      rx_gaps  = '{0, 2, 5, 1};
      run_main(vecs[v].save, vecs[v].load, vecs[v].pulse, vecs[v].stall, 1'b0, 80, fin);
      exp_acc = 0;
      if (vecs[v].exp_start) begin
        exp_acc = 2 * S;
        if (vecs[v].exp_save) exp_acc += 3 * int'(M_LEN) + vecs[v].stall;
        else foreach (rx_gaps[k]) exp_acc += 2 + rx_gaps[k];
      end
      check("vec_finished", fin, vecs[v].exp_start);
      check("vec_done_pulses", done_cnt, vecs[v].exp_start ? 1 : 0);
      check("vec_access_cycles", acc_cyc, exp_acc);
      check("vec_busy_cycles", busy_cyc, exp_acc);
      if (vecs[v].exp_start && vecs[v].exp_save) begin
        check("vec_first_valid_latency", first_vld + 1, 1 + S + 2);
        check_save("vec_save");
      end else if (vecs[v].exp_start) begin
        check_load("vec_load");
      end else begin
        check("vec_idle_no_tx", tx_q.size(), 0);
        check("vec_idle_no_write", wr_a_q.size(), 0);
      end
    end

    // address wrap and empty window, run side by side
    rx_bytes.delete(); rx_gaps.delete();
    clear_stats();
    w_save = 1; z_save = 1;
    tick();
    w_save = 0; z_save = 0;
    repeat (30) tick();
    check("wrap_count", w_addr_q.size(), 4);
    for (int k = 0; k < w_addr_q.size() && k < 4; k++) begin
      ea = W_BASE + 16'(k);
      ed = ea[7:0] ^ 8'h3C;
      check("wrap_addr", w_addr_q[k], ea);
      check("wrap_data", w_data_q[k], ed);
    end
    check("wrap_access_cycles", w_acc, 2 * S + 3 * 4);
    check("wrap_done", w_done_cnt, 1);
    check("zero_access_cycles", z_acc, 2 * S);
    check("zero_no_traffic", z_viol, 0);
    check("zero_done", z_done_cnt, 1);

    // asynchronous reset landing on the write strobe
    rx_bytes = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    rx_gaps  = '{0, 0, 0, 0};
    clear_stats();
    m_load = 1;
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      tick();
      fin = (wr_a_q.size() > 0);
    end
    check("rst_test_reached_wr_stb", fin, 1);
    #1 rst_n = 0;
    #1;
    check("async_rst_access", bus_m.hs_access, 0);
    check("async_rst_write", bus_m.hs_write, 0);
    check("async_rst_busy", m_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
    check("post_rst_busy", m_busy, 0);
    check("post_rst_access", bus_m.hs_access, 0);

    // randomized transfers against the reference RAM
    for (int t = 0; t < 8; t++) begin
      mode_save = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mode_save) begin
        for (int k = 0; k < int'(M_LEN); k++) preload(M_BASE + 16'(k), 8'($urandom));
        rx_bytes.delete(); rx_gaps.delete();
      end else begin
        rx_bytes.delete(); rx_gaps.delete();
        for (int k = 0; k < int'(M_LEN); k++) begin
          rx_bytes.push_back(8'($urandom));
          rx_gaps.push_back(0);
        end
      end
      run_main(mode_save, !mode_save, 1'b0, 0, 1'b1, 300, fin);
      check("rand_finished", fin, 1);
      check("rand_done_pulses", done_cnt, 1);
      if (mode_save) check_save("rand_save");
      else check_load("rand_load");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
